// File: rtl/elbeth_hazard_ctrl_pkg.sv
// Shared stage indices, port-waiter state encoding and defaults for the
// ELBETH stall/flush controller.
package elbeth_hazard_ctrl_pkg;

    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EXS = 2;

    localparam int DEFAULT_TIMEOUT = 255;
    localparam int DEFAULT_CNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } wait_state_t;

    // A waiting port holds its owning stage and every stage in front of it.
    function automatic logic owns_stage(input logic [3:0] owner, input int stage);
        return int'(owner) >= stage;
    endfunction

endpackage

// File: rtl/elbeth_hazard_ctrl_if.sv
// Memory-port handshake bundle between the pipeline's memory ports and the
// hazard controller.
interface elbeth_hazard_ctrl_if #(
    parameter int NUM_PORTS = 2
);
    logic [NUM_PORTS-1:0] port_en;
    logic [NUM_PORTS-1:0] port_ready;
    logic [NUM_PORTS-1:0] port_timeout;
    logic                 bus_error;

    modport master (
        output port_en,
        output port_ready,
        input  port_timeout,
        input  bus_error
    );

    modport slave (
        input  port_en,
        input  port_ready,
        output port_timeout,
        output bus_error
    );
endinterface

// File: rtl/elbeth_hazard_ctrl_port_waiter.sv
// Per-port wait tracker: IDLE/WAIT/DRAIN FSM with a saturating wait counter
// that raises a one-cycle timeout when the port has waited TIMEOUT cycles.
module elbeth_port_waiter
    import elbeth_hazard_ctrl_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic ready,
    output logic waiting,
    output logic timeout
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    wait_state_t      state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             expire;

    assign expire  = (state_reg == WAIT) & en & ~ready & (cnt_reg == TIMEOUT_C);
    // After a timeout the port is abandoned (DRAIN) so it no longer holds the pipe.
    assign waiting = ~rst & en & ~ready & (state_reg != DRAIN);
    assign timeout = ~rst & expire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (en & ~ready) begin
                        state_reg <= WAIT;
                        cnt_reg   <= CNT_W'(1);
                    end
                end
                WAIT: begin
                    if (~en | ready) begin
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == TIMEOUT_C) begin
                        state_reg <= DRAIN;
                        cnt_reg   <= '0;
                    end else if (cnt_reg != CNT_MAX) begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                DRAIN: begin
                    if (~en) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/elbeth_hazard_ctrl.sv
// Stall/flush controller for the ELBETH pipeline: memory back-pressure,
// load-use bubble, deferred branch flush and exception/bus-error flush.
module elbeth_hazard_ctrl
    import elbeth_hazard_ctrl_pkg::*;
#(
    parameter int                         NUM_STAGES = 3,
    parameter int                         NUM_PORTS  = 2,
    parameter logic [NUM_PORTS*4-1:0]     PORT_STAGE = {4'd2, 4'd0},
    parameter int                         TIMEOUT    = DEFAULT_TIMEOUT,
    parameter int                         CNT_W      = DEFAULT_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    elbeth_hazard_ctrl_if.slave   mem,
    input  logic                  id_load_use,
    input  logic                  id_branch_taken,
    input  logic                  exs_exception,
    output logic [NUM_STAGES-1:0] stall,
    output logic [NUM_STAGES-1:0] flush
);

    logic [NUM_PORTS-1:0]  port_wait;
    logic [NUM_PORTS-1:0]  port_to;
    logic [NUM_PORTS-1:0]  cover_mask [NUM_STAGES];
    logic [NUM_STAGES-1:0] mem_stall;
    logic [NUM_STAGES-1:0] base_stall;

    logic pend_flush_reg;
    logic pend_flush_next;
    logic exc;
    logic lu_bubble;
    logic branch_req;

    genvar gi, gj;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            elbeth_port_waiter #(
                .TIMEOUT (TIMEOUT),
                .CNT_W   (CNT_W)
            ) u_waiter (
                .clk     (clk),
                .rst     (rst),
                .en      (mem.port_en[gi]),
                .ready   (mem.port_ready[gi]),
                .waiting (port_wait[gi]),
                .timeout (port_to[gi])
            );
        end

        for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
            for (gj = 0; gj < NUM_PORTS; gj++) begin : g_cover
                assign cover_mask[gi][gj] = owns_stage(PORT_STAGE[gj*4 +: 4], gi);
            end
            assign mem_stall[gi] = |(port_wait & cover_mask[gi]);

            if (gi <= STG_ID) begin : g_lu
                assign base_stall[gi] = mem_stall[gi] | id_load_use;
            end else begin : g_nolu
                assign base_stall[gi] = mem_stall[gi];
            end
        end
    endgenerate

    assign mem.port_timeout = port_to;
    assign mem.bus_error    = |port_to;

    assign exc        = exs_exception | (|port_to);
    // A load still waiting on memory in EXS has not produced a result to bubble past.
    assign lu_bubble  = id_load_use & ~mem_stall[STG_EXS];
    assign branch_req = id_branch_taken | pend_flush_reg;

    always_comb begin
        stall           = base_stall;
        flush           = '0;
        pend_flush_next = pend_flush_reg;
        if (rst) begin
            stall           = '0;
            flush           = '1;
            pend_flush_next = 1'b0;
        end else if (exc) begin
            stall           = '0;
            flush           = '1;
            pend_flush_next = 1'b0;
        end else begin
            if (lu_bubble) begin
                flush[STG_EXS] = 1'b1;
            end
            // A redirect cannot bubble IF while it is held; remember it until released.
            if (base_stall[STG_IF]) begin
                pend_flush_next = branch_req;
            end else begin
                flush[STG_IF]   = branch_req;
                pend_flush_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_flush_reg <= 1'b0;
        end else begin
            pend_flush_reg <= pend_flush_next;
        end
    end

endmodule

// File: tb/tb_elbeth_hazard_ctrl.sv
// Directed bench for elbeth_hazard_ctrl: one table row per clock cycle,
// plus hand-written reset-during-wait sequences. TIMEOUT is 4 here.
module tb_elbeth_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_load_use = 1'b0;
    logic       id_branch_taken = 1'b0;
    logic       exs_exception = 1'b0;
    logic [2:0] stall;
    logic [2:0] flush;

    int checks   = 0;
    int failures = 0;

    elbeth_hazard_ctrl_if #(.NUM_PORTS(2)) mem_bus ();

    elbeth_hazard_ctrl #(
        .NUM_STAGES (3),
        .NUM_PORTS  (2),
        .PORT_STAGE ({4'd2, 4'd0}),
        .TIMEOUT    (4),
        .CNT_W      (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .mem             (mem_bus),
        .id_load_use     (id_load_use),
        .id_branch_taken (id_branch_taken),
        .exs_exception   (exs_exception),
        .stall           (stall),
        .flush           (flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [1:0] en;
        logic [1:0] rdy;
        logic       lu;
        logic       br;
        logic       exc;
        logic [2:0] e_stall;
        logic [2:0] e_flush;
        logic [1:0] e_to;
        logic       e_be;
        string      name;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [1:0] en, input logic [1:0] rdy,
                       input logic lu, input logic br, input logic exc,
                       input logic [2:0] es, input logic [2:0] ef,
                       input logic [1:0] eto, input logic ebe, input string name);
        vec_t v;
        v.rst = r; v.en = en; v.rdy = rdy; v.lu = lu; v.br = br; v.exc = exc;
        v.e_stall = es; v.e_flush = ef; v.e_to = eto; v.e_be = ebe; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic check(input string what, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", what, act, exp);
        end
    endtask

    // Drive one cycle's inputs at negedge, check combinational outputs 1ns later.
    task automatic apply(input vec_t v);
        @(negedge clk);
        rst                = v.rst;
        mem_bus.port_en    = v.en;
        mem_bus.port_ready = v.rdy;
        id_load_use        = v.lu;
        id_branch_taken    = v.br;
        exs_exception      = v.exc;
        #1;
        $display("cyc %s: stall=%b flush=%b to=%b be=%b", v.name, stall, flush,
                 mem_bus.port_timeout, mem_bus.bus_error);
        check({v.name, " stall"}, {5'd0, stall}, {5'd0, v.e_stall});
        check({v.name, " flush"}, {5'd0, flush}, {5'd0, v.e_flush});
        check({v.name, " timeout"}, {6'd0, mem_bus.port_timeout}, {6'd0, v.e_to});
        check({v.name, " bus_error"}, {7'd0, mem_bus.bus_error}, {7'd0, v.e_be});
        check({v.name, " stall&flush"}, {5'd0, stall & flush}, 8'd0);
    endtask

    task automatic step(input logic r, input logic [1:0] en, input logic [1:0] rdy,
                        input logic lu, input logic br, input logic exc,
                        input logic [2:0] es, input logic [2:0] ef,
                        input logic [1:0] eto, input logic ebe, input string name);
        vec_t v;
        v.rst = r; v.en = en; v.rdy = rdy; v.lu = lu; v.br = br; v.exc = exc;
        v.e_stall = es; v.e_flush = ef; v.e_to = eto; v.e_be = ebe; v.name = name;
        apply(v);
    endtask

    initial begin
        mem_bus.port_en    = 2'b00;
        mem_bus.port_ready = 2'b00;

        //   rst en     rdy    lu br ex  stall   flush   to     be  name
        add(1, 2'b00, 2'b00, 0, 0, 0, 3'b000, 3'b111, 2'b00, 0, "reset0");
        add(1, 2'b10, 2'b00, 0, 0, 0, 3'b000, 3'b111, 2'b00, 0, "reset_en");
        add(0, 2'b00, 2'b00, 0, 0, 0, 3'b000, 3'b000, 2'b00, 0, "idle");
        add(0, 2'b01, 2'b00, 0, 0, 0, 3'b001, 3'b000, 2'b00, 0, "imem_w1");
        add(0, 2'b01, 2'b00, 0, 0, 0, 3'b001, 3'b000, 2'b00, 0, "imem_w2");
        add(0, 2'b01, 2'b00, 0, 0, 0, 3'b001, 3'b000, 2'b00, 0, "imem_w3");
        add(0, 2'b01, 2'b01, 0, 0, 0, 3'b000, 3'b000, 2'b00, 0, "imem_rdy");
        add(0, 2'b00, 2'b00, 0, 0, 0, 3'b000, 3'b000, 2'b00, 0, "idle2");
        add(0, 2'b10, 2'b00, 0, 0, 0, 3'b111, 3'b000, 2'b00, 0, "dmem_w");
        add(0, 2'b10, 2'b10, 0, 0, 0, 3'b000, 3'b000, 2'b00, 0, "dmem_rdy");
        add(0, 2'b00, 2'b00, 0, 0, 0, 3'b000, 3'b000, 2'b00, 0, "idle3");
        add(0, 2'b00, 2'b00, 1, 0, 0, 3'b011, 3'b100, 2'b00, 0, "lu");
        add(0, 2'b10, 2'b00, 1, 0, 0, 3'b111, 3'b000, 2'b00, 0, "lu_dmem_w");
        add(0, 2'b10, 2'b10, 0, 0, 0, 3'b000, 3'b000, 2'b00, 0, "lu_dmem_rdy");
        add(0, 2'b00, 2'b00, 0, 0, 0, 3'b000, 3'b000, 2'b00, 0, "idle4");
        add(0, 2'b00, 2'b00, 0, 1, 0, 3'b000, 3'b001, 2'b00, 0, "br_free");
        add(0, 2'b01, 2'b00, 0, 1, 0, 3'b001, 3'b000, 2'b00, 0, "br_stalled");
        add(0, 2'b01, 2'b00, 0, 1, 0, 3'b001, 3'b000, 2'b00, 0, "br_again");
        add(0, 2'b01, 2'b00, 0, 0, 0, 3'b001, 3'b000, 2'b00, 0, "br_hold");
        add(0, 2'b01, 2'b01, 0, 0, 0, 3'b000, 3'b001, 2'b00, 0, "br_release");
        add(0, 2'b00, 2'b00, 0, 0, 0, 3'b000, 3'b000, 2'b00, 0, "br_once");
        add(0, 2'b00, 2'b00, 1, 1, 0, 3'b011, 3'b100, 2'b00, 0, "lu_br");
        add(0, 2'b00, 2'b00, 0, 0, 0, 3'b000, 3'b001, 2'b00, 0, "lu_br_pend");
        add(0, 2'b00, 2'b00, 0, 0, 0, 3'b000, 3'b000, 2'b00, 0, "idle5");
        add(0, 2'b10, 2'b00, 0, 0, 1, 3'b000, 3'b111, 2'b00, 0, "exc_dmem");
        add(0, 2'b00, 2'b00, 0, 0, 0, 3'b000, 3'b000, 2'b00, 0, "exc_after");
        add(0, 2'b01, 2'b00, 0, 1, 0, 3'b001, 3'b000, 2'b00, 0, "exc_pend_set");
        add(0, 2'b01, 2'b00, 0, 0, 1, 3'b000, 3'b111, 2'b00, 0, "exc_clear");
        add(0, 2'b01, 2'b01, 0, 0, 0, 3'b000, 3'b000, 2'b00, 0, "exc_no_pend");
        add(0, 2'b00, 2'b00, 0, 0, 0, 3'b000, 3'b000, 2'b00, 0, "idle6");
        add(0, 2'b10, 2'b00, 0, 0, 0, 3'b111, 3'b000, 2'b00, 0, "to_w1");
        add(0, 2'b10, 2'b00, 0, 0, 0, 3'b111, 3'b000, 2'b00, 0, "to_w2");
        add(0, 2'b10, 2'b00, 0, 0, 0, 3'b111, 3'b000, 2'b00, 0, "to_w3");
        add(0, 2'b10, 2'b00, 0, 0, 0, 3'b111, 3'b000, 2'b00, 0, "to_w4");
        add(0, 2'b10, 2'b00, 0, 0, 0, 3'b000, 3'b111, 2'b10, 1, "to_fire");
        add(0, 2'b10, 2'b00, 0, 0, 0, 3'b000, 3'b000, 2'b00, 0, "drain1");
        add(0, 2'b10, 2'b00, 0, 0, 0, 3'b000, 3'b000, 2'b00, 0, "drain2");
        add(0, 2'b00, 2'b00, 0, 0, 0, 3'b000, 3'b000, 2'b00, 0, "drain_exit");
        add(0, 2'b10, 2'b00, 0, 0, 0, 3'b111, 3'b000, 2'b00, 0, "rewait");
        add(0, 2'b00, 2'b00, 0, 0, 0, 3'b000, 3'b000, 2'b00, 0, "en_drop");
        add(0, 2'b11, 2'b00, 0, 0, 0, 3'b111, 3'b000, 2'b00, 0, "both_w1");
        add(0, 2'b11, 2'b00, 0, 0, 0, 3'b111, 3'b000, 2'b00, 0, "both_w2");
        add(0, 2'b11, 2'b00, 0, 0, 0, 3'b111, 3'b000, 2'b00, 0, "both_w3");
        add(0, 2'b11, 2'b00, 0, 0, 0, 3'b111, 3'b000, 2'b00, 0, "both_w4");
        add(0, 2'b11, 2'b00, 0, 0, 0, 3'b000, 3'b111, 2'b11, 1, "both_fire");
        add(0, 2'b11, 2'b00, 1, 0, 0, 3'b011, 3'b100, 2'b00, 0, "drain_lu");
        add(0, 2'b00, 2'b00, 0, 0, 0, 3'b000, 3'b000, 2'b00, 0, "both_exit");
        add(0, 2'b10, 2'b00, 0, 0, 0, 3'b111, 3'b000, 2'b00, 0, "edge_w1");
        add(0, 2'b10, 2'b00, 0, 0, 0, 3'b111, 3'b000, 2'b00, 0, "edge_w2");
        add(0, 2'b10, 2'b00, 0, 0, 0, 3'b111, 3'b000, 2'b00, 0, "edge_w3");
        add(0, 2'b10, 2'b00, 0, 0, 0, 3'b111, 3'b000, 2'b00, 0, "edge_w4");
        add(0, 2'b10, 2'b10, 0, 0, 0, 3'b000, 3'b000, 2'b00, 0, "edge_rdy");
        add(0, 2'b00, 2'b00, 0, 0, 0, 3'b000, 3'b000, 2'b00, 0, "idle7");

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
        end

        // Reset during a wait with a branch pending: the pending flush must not survive.
        step(0, 2'b10, 2'b00, 0, 0, 0, 3'b111, 3'b000, 2'b00, 0, "rp_w1");
        step(0, 2'b10, 2'b00, 0, 0, 0, 3'b111, 3'b000, 2'b00, 0, "rp_w2");
        step(0, 2'b10, 2'b00, 0, 1, 0, 3'b111, 3'b000, 2'b00, 0, "rp_br");
        step(1, 2'b10, 2'b00, 0, 0, 0, 3'b000, 3'b111, 2'b00, 0, "rp_rst");
        step(0, 2'b00, 2'b00, 0, 0, 0, 3'b000, 3'b000, 2'b00, 0, "rp_no_flush");

        // Reset after three wait cycles: counter restarts, so a full TIMEOUT is needed again.
        step(0, 2'b10, 2'b00, 0, 0, 0, 3'b111, 3'b000, 2'b00, 0, "rc_w1");
        step(0, 2'b10, 2'b00, 0, 0, 0, 3'b111, 3'b000, 2'b00, 0, "rc_w2");
        step(0, 2'b10, 2'b00, 0, 0, 0, 3'b111, 3'b000, 2'b00, 0, "rc_w3");
        step(1, 2'b10, 2'b00, 0, 0, 0, 3'b000, 3'b111, 2'b00, 0, "rc_rst");
        step(0, 2'b10, 2'b00, 0, 0, 0, 3'b111, 3'b000, 2'b00, 0, "rc_n1");
        step(0, 2'b10, 2'b00, 0, 0, 0, 3'b111, 3'b000, 2'b00, 0, "rc_n2");
        step(0, 2'b10, 2'b00, 0, 0, 0, 3'b111, 3'b000, 2'b00, 0, "rc_n3");
        step(0, 2'b10, 2'b00, 0, 0, 0, 3'b111, 3'b000, 2'b00, 0, "rc_n4");
        step(0, 2'b10, 2'b00, 0, 0, 0, 3'b000, 3'b111, 2'b10, 1, "rc_fire");
        step(0, 2'b00, 2'b00, 0, 0, 0, 3'b000, 3'b000, 2'b00, 0, "rc_exit");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/elbeth_hazard_ctrl.md
Name: elbeth_hazard_ctrl

Overview:
- Parametrised stall/flush controller for the ELBETH pipeline; next generation of the memory-stall logic in elbeth_control_unit.
- Supports N memory ports, each owned by a configurable pipeline stage.
- Adds per-port wait FSMs with a timeout/bus-error path, a one-bubble load-use interlock, and pending-flush buffering while a stage is stalled.
- Sits beside the control unit; drives per-stage stall and flush vectors to the pipeline registers.

Parameters:
- NUM_STAGES, 3, number of pipeline stages (0 = IF, 1 = ID, 2 = EXS).
- NUM_PORTS, 2, number of memory ports (default: port0 = imem, port1 = dmem).
- PORT_STAGE, {4'd2,4'd0}, packed NUM_PORTS x 4-bit owning-stage index per port; each value < NUM_STAGES.
- TIMEOUT, 255, wait cycles before a port declares a bus error; must be > 0.
- CNT_W, 8, counter width; TIMEOUT < 2^CNT_W.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- port_en  input  NUM_PORTS  memory request enable per port
- port_ready  input  NUM_PORTS  memory ready per port
- id_load_use  input  1  ID instruction depends on a load currently in EXS
- id_branch_taken  input  1  redirect; flush stage 0
- exs_exception  input  1  exception in the last stage; flush all stages
- stall  output  NUM_STAGES  stall[k] holds pipeline register k
- flush  output  NUM_STAGES  flush[k] bubbles pipeline register k
- port_timeout  output  NUM_PORTS  one-cycle bus-error pulse per port
- bus_error  output  1  OR of port_timeout

Behaviour:
- Reset (rst=1 at a clk edge):
  - All FSMs go to IDLE; counters = 0; pend_flush = 0.
  - While rst is high: stall = 0, flush = all ones, port_timeout = 0, bus_error = 0.
- Per-port FSM:
  - States: IDLE, WAIT, DRAIN.
  - IDLE -> WAIT when en & ~ready (counter = 1).
  - WAIT -> IDLE when ready, or when en drops.
  - WAIT, counter == TIMEOUT and still ~ready: pulse port_timeout[p] that cycle, go to DRAIN.
  - Otherwise in WAIT, counter increments and saturates.
  - DRAIN -> IDLE when en = 0. In DRAIN the port raises no stall.
- Port wait (combinational, zero latency):
  - wait[p] = en & ~ready & (state != DRAIN).
  - A ready in the same cycle as en gives no stall.
- Stall back-pressure: stall[k] = 1 if any waiting port has PORT_STAGE >= k, or if the load-use interlock applies (k <= 1).
- Load-use interlock:
  - id_load_use = 1 -> stall[0] = stall[1] = 1 and flush[2] = 1 (one bubble).
  - Suppressed if the EXS stage is memory-stalled; stall only in that case.
- Branch flush:
  - Request = id_branch_taken.
  - If stall[0] = 0: flush[0] = 1 in the same cycle.
  - If stall[0] = 1: set pend_flush; flush[0] asserts in the first cycle stall[0] = 0; pend_flush then clears.
  - A new branch while pend_flush is set is absorbed (still one flush).
- Exception / bus error:
  - exs_exception | bus_error -> flush = all ones and stall = 0 in that cycle; pend_flush clears.
  - Highest priority over load-use and branch.
- General rule: flush[k] and stall[k] are never both 1, except during the exception case, where flush wins and stall is forced to 0.
- Simultaneous timeouts on several ports:
  - Each pulses its own bit; bus_error is a single OR.

Decomposition:
- elbeth_pkg holds:
  - Stage index constants STG_IF = 0, STG_ID = 1, STG_EXS = 2.
  - FSM state encodings (IDLE = 2'd0, WAIT = 2'd1, DRAIN = 2'd2).
  - Default TIMEOUT.
- Sub-module elbeth_port_waiter: one per port via generate. Contains the FSM and counter; outputs wait and timeout.
- Top level: back-pressure OR-reduction, interlock, pend_flush register, priority logic.

Test Plan:
- Imem wait: port_en = 01, port_ready = 00 for 3 cycles, then ready = 01 -> stall = 001 for 3 cycles, then 000; no timeout.
- Dmem wait: port_en = 10, ready = 00 -> stall = 111. Then ready = 10 -> stall = 000 in the same cycle.
- Timeout with TIMEOUT = 4: dmem en held, ready low.
  - stall = 111 for 4 cycles.
  - 5th cycle: port_timeout = 10, bus_error = 1, flush = 111.
  - Then stall = 000 (DRAIN) until en drops.
- Load-use: id_load_use = 1 for 1 cycle, no waits -> stall = 011, flush = 100. With dmem waiting -> stall = 111, flush = 000.
- Branch during stall: imem waiting and id_branch_taken pulsed -> flush = 000 while stalled. On the ready cycle: stall = 000, flush = 001, once only.
- Reset mid-WAIT: rst during dmem wait -> next cycle FSM in IDLE, counter = 0, pend_flush = 0. While rst is high: flush = 111, stall = 000.
